// File: rtl/ieee754_compose_seq.sv
// ieee754_compose_seq
// Multi-cycle normalise / round / pack unit producing an IEEE-754 single
// from a sign, a signed biased exponent (bias 127) and an unnormalised
// extended mantissa. One operand is in flight at a time; both sides use a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready is high only when idle
//   in_sign              result sign
//   in_exp               signed biased exponent (EXP_W bits)
//   in_mant              [27]=carry [26]=hidden [25:3]=fraction
//                        [2]=guard [1]=round [0]=sticky
//   out_valid/out_ready  result handshake; result held until consumed
//   out_float            packed IEEE-754 single
//   out_overflow         result rounded to infinity
//   out_underflow        result tiny (exp field 0) and inexact
//   out_inexact          some nonzero bit was discarded
module ieee754_compose_seq #(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_float,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic              out_inexact
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic signed [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_FLUSH = EXP_W'(-26);
  localparam logic signed [EXP_W-1:0] EXP_MAX   = EXP_W'(255);

  logic [1:0]               state;
  logic                     sign_r;
  logic signed [EXP_W-1:0]  exp_r;
  logic [MANT_W-1:0]        mant_r;

  // Normalisation decisions, evaluated in priority order in NORM.
  logic mant_zero, do_flush, do_right, do_left;

  always_comb begin
    mant_zero = (mant_r == '0);
    // Below this exponent every bit lands under the sticky position, so the
    // whole mantissa collapses to sticky in a single step.
    do_flush  = (exp_r < EXP_FLUSH);
    do_right  = mant_r[27] | (exp_r < EXP_ONE);
    do_left   = ~mant_r[26] & (exp_r > EXP_ONE);
  end

  // Round-to-nearest-even on the normalised (or exp==1 denormal) mantissa.
  logic                    rnd_inc, rnd_inexact, rnd_carry, rnd_ovf;
  logic [24:0]             rnd_sum;
  logic [23:0]             rnd_sig;
  logic signed [EXP_W-1:0] rnd_exp;
  logic [7:0]              rnd_field;

  always_comb begin
    rnd_inc     = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
    rnd_inexact = |mant_r[2:0];
    // mant_r[27] is always clear once NORM hands over, so 25 bits suffice.
    rnd_sum     = mant_r[27:3] + {24'd0, rnd_inc};
    rnd_carry   = rnd_sum[24];
    rnd_sig     = rnd_carry ? rnd_sum[24:1] : rnd_sum[23:0];
    rnd_exp     = exp_r + {{(EXP_W-1){1'b0}}, rnd_carry};
    rnd_ovf     = (rnd_exp >= EXP_MAX);
    // A denormal that rounds up into the hidden bit becomes the smallest
    // normal, since exp_r is 1 in that case.
    rnd_field   = rnd_sig[23] ? rnd_exp[7:0] : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sign_r        <= 1'b0;
      exp_r         <= '0;
      mant_r        <= '0;
      out_float     <= 32'd0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= in_sign;
            exp_r  <= in_exp;
            mant_r <= in_mant;
            state  <= NORM;
          end
        end
        NORM: begin
          if (mant_zero) begin
            out_float     <= {sign_r, 31'd0};
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
            state         <= DONE;
          end else if (do_flush) begin
            mant_r <= {{(MANT_W-1){1'b0}}, |mant_r};
            exp_r  <= EXP_ONE;
          end else if (do_right) begin
            // The bit shifted out is folded into the sticky bit.
            mant_r <= {1'b0, mant_r[MANT_W-1:2], mant_r[1] | mant_r[0]};
            exp_r  <= exp_r + EXP_ONE;
          end else if (do_left) begin
            mant_r <= {mant_r[MANT_W-2:0], 1'b0};
            exp_r  <= exp_r - EXP_ONE;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          if (rnd_ovf) begin
            out_float     <= {sign_r, 8'hFF, 23'd0};
            out_overflow  <= 1'b1;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b1;
          end else begin
            out_float     <= {sign_r, rnd_field, rnd_sig[22:0]};
            out_overflow  <= 1'b0;
            out_underflow <= (rnd_field == 8'd0) & rnd_inexact;
            out_inexact   <= rnd_inexact;
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_ieee754_compose_seq.sv
// Testbench for ieee754_compose_seq: directed vector table, hand-written
// handshake/reset sequences and randomized operands checked against an
// exact-arithmetic rounding model.
module tb_ieee754_compose_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_float;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  int checks = 0;
  int errors = 0;
  int op_num = 0;

  localparam int BUDGET = 100;

  ieee754_compose_seq #(.EXP_W(10), .MANT_W(28)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_float    (out_float),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow),
    .out_inexact  (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Exact reference: value = m * 2^(e-153); round to nearest even at the
  // quantum of the result (normal: 24 significant bits, denormal: 2^-149).
  function automatic void ref_model(input logic s, input int e, input logic [27:0] m,
                                    output logic [31:0] f, output logic [2:0] fl);
    int p, biased, sh;
    logic [63:0] mm, r, rem, half;
    logic ov, un, ix;
    if (m == 0) begin
      f  = {s, 31'd0};
      fl = 3'b000;
      return;
    end
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    biased = p + e - 26;
    sh = (biased >= 1) ? p - 23 : 4 - e;
    mm = 64'(m);
    ix = 1'b0;
    if (sh <= 0) begin
      r = mm << (-sh);
    end else begin
      if (sh > 30) sh = 30;
      r    = mm >> sh;
      rem  = mm & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      ix   = (rem != 0);
      if (rem > half || (rem == half && r[0])) r = r + 64'd1;
    end
    if (biased < 1) biased = 1;
    if (r >= (64'd1 << 24)) begin
      r = r >> 1;
      biased++;
    end
    ov = 1'b0;
    un = 1'b0;
    if (biased >= 255) begin
      f  = {s, 8'hFF, 23'd0};
      ov = 1'b1;
      ix = 1'b1;
    end else if (r >= (64'd1 << 23)) begin
      f = {s, 8'(biased), r[22:0]};
    end else begin
      f  = {s, 8'd0, r[22:0]};
      un = ix;
    end
    fl = {ov, un, ix};
  endfunction

  // Issue one operand from idle, wait for the result, hold it for `hold`
  // cycles under backpressure, then consume it.
  task automatic run_op(input logic s, input int e, input logic [27:0] m, input int hold,
                        output logic [31:0] f, output logic [2:0] fl, output int lat);
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_sign  = s;
    in_exp   = e[9:0];
    in_mant  = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_within_budget", 32'(out_valid), 32'd1);
    f  = out_float;
    fl = {out_overflow, out_underflow, out_inexact};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_float", out_float, f);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("consumed_out_valid", 32'(out_valid), 32'd0);
    check("consumed_in_ready", 32'(in_ready), 32'd1);
    op_num++;
    $display("op %0d: s=%0b e=%0d m=%h -> float=%h ovf/unf/inx=%b lat=%0d",
             op_num, s, e, m, f, fl, lat);
  endtask

  typedef struct {
    logic        s;
    int          e;
    logic [27:0] m;
    logic [31:0] f;
    logic [2:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [31:0] f, rf;
    logic [2:0]  fl, rfl;
    int          lat;
    logic [27:0] m;
    int          e;

    vecs[0]  = '{1'b0, 127, 28'h4000000, 32'h3F800000, 3'b000, 2};
    vecs[1]  = '{1'b0, 127, 28'hC000000, 32'h40400000, 3'b000, 3};
    vecs[2]  = '{1'b0, 127, 28'h0000008, 32'h34000000, 3'b000, 25};
    vecs[3]  = '{1'b0, 127, 28'h400000C, 32'h3F800002, 3'b001, 2};
    vecs[4]  = '{1'b0, 127, 28'h4000004, 32'h3F800000, 3'b001, 2};
    vecs[5]  = '{1'b0, 254, 28'h8000000, 32'h7F800000, 3'b101, 3};
    vecs[6]  = '{1'b1, 127, 28'h0000000, 32'h80000000, 3'b000, 1};
    vecs[7]  = '{1'b0, 1,   28'h2000000, 32'h00400000, 3'b000, 2};
    vecs[8]  = '{1'b0, -40, 28'h4000000, 32'h00000000, 3'b011, 3};
    vecs[9]  = '{1'b0, 127, 28'h4000007, 32'h3F800001, 3'b001, 2};
    vecs[10] = '{1'b0, 127, 28'h7FFFFFC, 32'h40000000, 3'b001, 2};
    vecs[11] = '{1'b0, 1,   28'h3FFFFFC, 32'h00800000, 3'b001, 2};
    vecs[12] = '{1'b0, 254, 28'h7FFFFFC, 32'h7F800000, 3'b101, 2};
    vecs[13] = '{1'b1, -26, 28'h4000000, 32'h80000000, 3'b011, 29};
    vecs[14] = '{1'b0, -27, 28'h4000000, 32'h00000000, 3'b011, 3};
    vecs[15] = '{1'b0, 1,   28'h0000008, 32'h00000001, 3'b000, 2};
    vecs[16] = '{1'b0, 254, 28'h7FFFFF8, 32'h7F7FFFFF, 3'b000, 2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_float", out_float, 32'd0);
    check("reset_flags", {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].s, vecs[i].e, vecs[i].m, 0, f, fl, lat);
      check($sformatf("vec%0d_float", i), f, vecs[i].f);
      check($sformatf("vec%0d_flags", i), 32'(fl), 32'(vecs[i].fl));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result held for 10 cycles.
    run_op(1'b0, 127, 28'h400000C, 10, f, fl, lat);
    check("bp_float", f, 32'h3F800002);

    // Consume cycle with a new operand offered: must not be accepted then.
    in_sign  = 1'b0;
    in_exp   = 10'd127;
    in_mant  = 28'h4000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ovl_first_valid", 32'(out_valid), 32'd1);
    in_sign   = 1'b0;
    in_exp    = 10'd127;
    in_mant   = 28'hC000000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ovl_not_accepted_in_ready", 32'(in_ready), 32'd1);
    check("ovl_out_valid_dropped", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ovl_accepted_next", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ovl_second_latency", 32'(lat), 32'd3);
    check("ovl_second_float", out_float, 32'h40400000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    op_num++;
    $display("op %0d: overlap sequence second result float=%h lat=%0d", op_num, out_float, lat);

    // Reset during NORM discards the operand.
    in_sign  = 1'b1;
    in_exp   = 10'd127;
    in_mant  = 28'h0000008;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_norm_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_out_float", out_float, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op_num++;
    $display("op %0d: reset asserted mid-normalisation", op_num);
    run_op(1'b0, 127, 28'h4000000, 0, f, fl, lat);
    check("post_rst_float", f, 32'h3F800000);
    check("post_rst_latency", 32'(lat), 32'd2);

    // Randomized operands against the exact model.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: e = int'($urandom_range(100, 160));
        1: e = int'($urandom_range(0, 60)) - 40;
        2: e = int'($urandom_range(230, 300));
        default: e = int'($urandom_range(0, 460)) - 60;
      endcase
      m = 28'($urandom);
      m = m >> $urandom_range(0, 28);
      if ($urandom_range(0, 15) == 0) m = '0;
      ref_model(1'($urandom), e, m, rf, rfl);
      run_op(rf[31], e, m, $urandom_range(0, 2), f, fl, lat);
      check($sformatf("rand%0d_float", i), f, rf);
      check($sformatf("rand%0d_flags", i), 32'(fl), 32'(rfl));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
